// File: rtl/volt_dac_ramp_if.sv
// rtl/volt_dac_ramp_if.sv - SPI pin bundle between the voltage ramp and the external DAC
interface volt_dac_ramp_if;
    logic dacCSn;
    logic dacSCLK;
    logic dacSDI;

    modport master (
        output dacCSn,
        output dacSCLK,
        output dacSDI
    );

    modport slave (
        input dacCSn,
        input dacSCLK,
        input dacSDI
    );
endinterface

// File: rtl/volt_dac_ramp.sv
// rtl/volt_dac_ramp.sv - filtered command capture, slew-limited ramp and 16-bit SPI DAC writer
module volt_dac_ramp #(
    parameter int CLK_DIV   = 5,
    parameter int RAMP_STEP = 16,
    parameter int RAMP_TICK = 100000
) (
    input  logic                  clk_100M,
    input  logic                  n_rst,
    input  logic [15:0]           comVolt,
    volt_dac_ramp_if.master       dac,
    output logic [15:0]           curVolt,
    output logic                  dacBusy,
    output logic                  rampDone
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(RAMP_TICK - 1);
    localparam logic [15:0] STEP16    = 16'(RAMP_STEP);
    localparam logic [16:0] STEP17    = {1'b0, STEP16};
    localparam logic [8:0]  HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0]  HOLD_LAST = 9'(2 * CLK_DIV - 1);

    // Command capture and ramp state
    logic [15:0] s1_q, s2_q;
    logic [15:0] target_q, target_d;
    logic [15:0] cur_q, cur_d;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic        tick;
    logic        ramp_step;
    logic [16:0] up_diff, dn_diff;

    // SPI frame state
    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [8:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic        busy_q, busy_d;

    // Target only follows the bus value once two consecutive samples agree
    always_comb begin
        target_d   = target_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
        up_diff    = {1'b0, target_q} - {1'b0, cur_q};
        dn_diff    = {1'b0, cur_q} - {1'b0, target_q};
        cur_d      = cur_q;
        ramp_step  = 1'b0;

        if (s1_q == s2_q) begin
            target_d = s2_q;
        end

        // Step is clamped to the remaining distance so the ramp never overshoots or wraps
        if (tick) begin
            if (cur_q < target_q) begin
                cur_d     = cur_q + ((up_diff > STEP17) ? STEP16 : up_diff[15:0]);
                ramp_step = 1'b1;
            end else if (cur_q > target_q) begin
                cur_d     = cur_q - ((dn_diff > STEP17) ? STEP16 : dn_diff[15:0]);
                ramp_step = 1'b1;
            end
        end
    end

    // Frame sequencer: SETUP, 16 SCLK periods high-then-low, CS hold gap
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        div_d     = div_q;
        bit_d     = bit_q;
        csn_d     = csn_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    shadow_d  = cur_q;
                    pending_d = 1'b0;
                    csn_d     = 1'b0;
                    sdi_d     = cur_q[15];
                    busy_d    = 1'b1;
                    div_d     = 9'd0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == HALF_LAST) begin
                    div_d   = 9'd0;
                    sclk_d  = 1'b1;
                    bit_d   = 4'd0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 9'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q == HALF_LAST) begin
                    div_d = 9'd0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit; after the last bit the line parks low
                        sclk_d = 1'b0;
                        sdi_d  = (bit_q == 4'd15) ? 1'b0 : shadow_q[4'd14 - bit_q];
                    end else if (bit_q == 4'd15) begin
                        csn_d   = 1'b1;
                        sdi_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 9'd1;
                end
            end
            ST_HOLD: begin
                if (div_q == HOLD_LAST) begin
                    div_d   = 9'd0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + 9'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A ramp step always wins over the launch clearing pending, so no value is lost
        if (ramp_step) begin
            pending_d = 1'b1;
        end
    end

    // State registers; reset queues a 0x0000 frame so the DAC matches curVolt
    always_ff @(posedge clk_100M or negedge n_rst) begin
        if (!n_rst) begin
            s1_q       <= 16'd0;
            s2_q       <= 16'd0;
            target_q   <= 16'd0;
            cur_q      <= 16'd0;
            tick_cnt_q <= 24'd0;
            state_q    <= ST_IDLE;
            pending_q  <= 1'b1;
            shadow_q   <= 16'd0;
            div_q      <= 9'd0;
            bit_q      <= 4'd0;
            csn_q      <= 1'b1;
            sclk_q     <= 1'b0;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= comVolt;
            s2_q       <= s1_q;
            target_q   <= target_d;
            cur_q      <= cur_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            csn_q      <= csn_d;
            sclk_q     <= sclk_d;
            sdi_q      <= sdi_d;
            busy_q     <= busy_d;
        end
    end

    assign dac.dacCSn  = csn_q;
    assign dac.dacSCLK = sclk_q;
    assign dac.dacSDI  = sdi_q;
    assign curVolt     = cur_q;
    assign dacBusy     = busy_q;
    assign rampDone    = (cur_q == target_q) && !pending_q && (state_q == ST_IDLE);

endmodule

// File: tb/tb_volt_dac_ramp.sv
// tb/tb_volt_dac_ramp.sv - randomized self-checking bench for volt_dac_ramp
module tb_volt_dac_ramp;

    localparam int TB_CLK_DIV = 5;
    localparam int TB_STEP    = 16;
    localparam int TB_TICK    = 8;
    localparam int FRAME_LOW  = 33 * TB_CLK_DIV;
    localparam int FRAME_BUSY = 35 * TB_CLK_DIV;
    localparam int FRAME_GAP  = 2 * TB_CLK_DIV + 1;

    typedef logic [15:0] vq_t[$];
    typedef struct {
        logic [15:0] val;
        int          bits;
        int          low;
        int          gap;
    } frame_t;

    logic        clk;
    logic        n_rst;
    logic [15:0] comVolt;
    logic [15:0] curVolt;
    logic        dacBusy;
    logic        rampDone;

    volt_dac_ramp_if dac_if ();

    volt_dac_ramp #(
        .CLK_DIV   (TB_CLK_DIV),
        .RAMP_STEP (TB_STEP),
        .RAMP_TICK (TB_TICK)
    ) dut (
        .clk_100M (clk),
        .n_rst    (n_rst),
        .comVolt  (comVolt),
        .dac      (dac_if),
        .curVolt  (curVolt),
        .dacBusy  (dacBusy),
        .rampDone (rampDone)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;
    int model_cur = 0;

    frame_t      frames[$];
    logic [15:0] chg_v[$];
    int          chg_t[$];
    int          mon_bits;
    int          cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame decoder: SDI is taken on each SCLK rise while CSn is low
    initial begin
        logic        in_frame;
        logic        have_prev;
        logic        prev_sclk;
        logic [15:0] val;
        int          low_len;
        int          high_len;
        int          gap;
        frame_t      f;
        in_frame  = 1'b0;
        have_prev = 1'b0;
        prev_sclk = 1'b0;
        val       = 16'd0;
        low_len   = 0;
        high_len  = 0;
        gap       = -1;
        mon_bits  = 0;
        forever begin
            @(negedge clk);
            if (n_rst !== 1'b1) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
                mon_bits  = 0;
                prev_sclk = 1'b0;
            end else begin
                if (in_frame) begin
                    if (dac_if.dacCSn === 1'b1) begin
                        f.val  = val;
                        f.bits = mon_bits;
                        f.low  = low_len;
                        f.gap  = gap;
                        frames.push_back(f);
                        in_frame  = 1'b0;
                        have_prev = 1'b1;
                        high_len  = 1;
                    end else begin
                        low_len++;
                        if (dac_if.dacSCLK === 1'b1 && prev_sclk === 1'b0) begin
                            val = {val[14:0], dac_if.dacSDI};
                            mon_bits++;
                        end
                    end
                end else if (dac_if.dacCSn === 1'b0) begin
                    in_frame = 1'b1;
                    gap      = have_prev ? high_len : -1;
                    low_len  = 1;
                    val      = 16'd0;
                    mon_bits = 0;
                end else begin
                    high_len++;
                end
                prev_sclk = dac_if.dacSCLK;
            end
        end
    end

    // Records every curVolt change with its cycle number
    initial begin
        logic [15:0] prev_cur;
        prev_cur = 16'd0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (curVolt !== prev_cur) begin
                chg_v.push_back(curVolt);
                chg_t.push_back(cyc);
            end
            prev_cur = curVolt;
        end
    end

    // Reference ramp: the sequence of codes a slew-limited walk from one value to another visits
    function automatic vq_t ramp_model(input int from_v, input int to_v);
        vq_t q;
        int  v;
        v = from_v;
        while (v != to_v) begin
            if (v < to_v) v += ((to_v - v) > TB_STEP) ? TB_STEP : (to_v - v);
            else          v -= ((v - to_v) > TB_STEP) ? TB_STEP : (v - to_v);
            q.push_back(16'(v));
        end
        return q;
    endfunction

    task automatic test_reset();
        int ok;
        int busy_len;
        n_rst   = 1'b0;
        comVolt = 16'h0000;
        repeat (3) @(negedge clk);
        check_cnt++; if (dac_if.dacCSn !== 1'b1) $display("FAIL reset_csn got=%b exp=1", dac_if.dacCSn); else pass_cnt++;
        check_cnt++; if (dac_if.dacSCLK !== 1'b0) $display("FAIL reset_sclk got=%b exp=0", dac_if.dacSCLK); else pass_cnt++;
        check_cnt++; if (dac_if.dacSDI !== 1'b0) $display("FAIL reset_sdi got=%b exp=0", dac_if.dacSDI); else pass_cnt++;
        check_cnt++; if (curVolt !== 16'h0000) $display("FAIL reset_cur got=%h exp=0000", curVolt); else pass_cnt++;
        check_cnt++; if (dacBusy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", dacBusy); else pass_cnt++;
        check_cnt++; if (rampDone !== 1'b0) $display("FAIL reset_done got=%b exp=0", rampDone); else pass_cnt++;
        frames.delete();
        n_rst = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dacBusy === 1'b1) begin ok = 1; break; end
        end
        check_cnt++; if (ok != 1) $display("FAIL reset_frame_start got=%0d exp=1", ok); else pass_cnt++;
        busy_len = 0;
        for (int i = 0; i < 400; i++) begin
            if (dacBusy !== 1'b1) break;
            busy_len++;
            @(negedge clk);
        end
        check_cnt++; if (busy_len != FRAME_BUSY) $display("FAIL reset_busy_len got=%0d exp=%0d", busy_len, FRAME_BUSY); else pass_cnt++;
        check_cnt++; if (rampDone !== 1'b1) $display("FAIL reset_done_after got=%b exp=1", rampDone); else pass_cnt++;
        repeat (300) @(negedge clk);
        check_cnt++; if (frames.size() != 1) $display("FAIL reset_frame_count got=%0d exp=1", frames.size()); else pass_cnt++;
        if (frames.size() >= 1) begin
            check_cnt++; if (frames[0].val !== 16'h0000) $display("FAIL reset_frame_val got=%h exp=0000", frames[0].val); else pass_cnt++;
            check_cnt++; if (frames[0].low != FRAME_LOW) $display("FAIL reset_csn_low got=%0d exp=%0d", frames[0].low, FRAME_LOW); else pass_cnt++;
            check_cnt++; if (frames[0].bits != 16) $display("FAIL reset_frame_bits got=%0d exp=16", frames[0].bits); else pass_cnt++;
        end
        model_cur = 0;
    endtask

    task automatic test_ramp(input logic [15:0] nv);
        vq_t exp_q;
        int  ok;
        int  n;
        int  j;
        exp_q = ramp_model(model_cur, int'(nv));
        n     = exp_q.size();
        chg_v.delete();
        chg_t.delete();
        frames.delete();
        comVolt = nv;
        repeat (4) @(negedge clk);
        ok = 0;
        for (int i = 0; i < (n + 2) * TB_TICK + 3 * FRAME_BUSY + 50; i++) begin
            if (rampDone === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check_cnt++; if (ok != 1) $display("FAIL ramp_done_timeout target=%h got=%0d exp=1", nv, ok); else pass_cnt++;
        check_cnt++; if (curVolt !== nv) $display("FAIL ramp_final_cur got=%h exp=%h", curVolt, nv); else pass_cnt++;
        check_cnt++; if (chg_v.size() != n) $display("FAIL ramp_step_count target=%h got=%0d exp=%0d", nv, chg_v.size(), n); else pass_cnt++;
        for (int i = 0; i < n && i < chg_v.size(); i++) begin
            check_cnt++;
            if (chg_v[i] !== exp_q[i]) begin
                $display("FAIL ramp_step_val idx=%0d got=%h exp=%h", i, chg_v[i], exp_q[i]);
                break;
            end else pass_cnt++;
        end
        for (int i = 1; i < chg_t.size(); i++) begin
            check_cnt++;
            if (chg_t[i] - chg_t[i-1] != TB_TICK) begin
                $display("FAIL ramp_tick_spacing idx=%0d got=%0d exp=%0d", i, chg_t[i] - chg_t[i-1], TB_TICK);
                break;
            end else pass_cnt++;
        end
        if (n == 0) begin
            check_cnt++; if (frames.size() != 0) $display("FAIL ramp_idle_frames got=%0d exp=0", frames.size()); else pass_cnt++;
        end else begin
            check_cnt++; if (frames.size() < 1) $display("FAIL ramp_frame_count got=%0d exp>=1", frames.size()); else pass_cnt++;
            if (frames.size() >= 1) begin
                check_cnt++;
                if (frames[frames.size()-1].val !== nv) $display("FAIL ramp_last_frame got=%h exp=%h", frames[frames.size()-1].val, nv);
                else pass_cnt++;
            end
            j = 0;
            for (int i = 0; i < frames.size(); i++) begin
                while (j < n && exp_q[j] !== frames[i].val) j++;
                check_cnt++;
                if (j >= n) begin
                    $display("FAIL ramp_frame_order idx=%0d got=%h exp=later_ramp_code", i, frames[i].val);
                    break;
                end else pass_cnt++;
                j++;
                check_cnt++;
                if (frames[i].low != FRAME_LOW || frames[i].bits != 16) begin
                    $display("FAIL ramp_frame_shape idx=%0d got=low%0d/bits%0d exp=low%0d/bits16", i, frames[i].low, frames[i].bits, FRAME_LOW);
                    break;
                end else pass_cnt++;
                if (i > 0) begin
                    check_cnt++;
                    if (frames[i].gap != FRAME_GAP) begin
                        $display("FAIL ramp_frame_gap idx=%0d got=%0d exp=%0d", i, frames[i].gap, FRAME_GAP);
                        break;
                    end else pass_cnt++;
                end
            end
        end
        model_cur = int'(nv);
    endtask

    task automatic test_clamp();
        test_ramp(16'h0045);
        test_ramp(16'h0008);
        test_ramp(16'h0000);
    endtask

    task automatic test_glitch();
        vq_t exp_q;
        int  lat;
        int  ok;
        test_ramp(16'h0200);
        exp_q = ramp_model(model_cur, 16'h00FF);
        chg_v.delete();
        chg_t.delete();
        comVolt = 16'h1234;
        @(negedge clk);
        comVolt = 16'h00FF;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rampDone !== 1'b1) break;
        end
        check_cnt++; if (lat != 3) $display("FAIL glitch_target_latency got=%0d exp=3", lat); else pass_cnt++;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rampDone === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check_cnt++; if (ok != 1) $display("FAIL glitch_done_timeout got=%0d exp=1", ok); else pass_cnt++;
        check_cnt++; if (chg_v.size() != exp_q.size()) $display("FAIL glitch_step_count got=%0d exp=%0d", chg_v.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < chg_v.size() && i < exp_q.size(); i++) begin
            check_cnt++;
            if (chg_v[i] !== exp_q[i]) begin
                $display("FAIL glitch_step_val idx=%0d got=%h exp=%h", i, chg_v[i], exp_q[i]);
                break;
            end else pass_cnt++;
        end
        check_cnt++; if (curVolt !== 16'h00FF) $display("FAIL glitch_final_cur got=%h exp=00ff", curVolt); else pass_cnt++;
        model_cur = 16'h00FF;
    endtask

    task automatic test_back_to_back();
        int ok;
        test_ramp(16'h0000);
        frames.delete();
        comVolt = 16'h0100;
        repeat (4) @(negedge clk);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rampDone === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check_cnt++; if (ok != 1) $display("FAIL b2b_done_timeout got=%0d exp=1", ok); else pass_cnt++;
        check_cnt++; if (frames.size() < 2) $display("FAIL b2b_frame_count got=%0d exp>=2", frames.size()); else pass_cnt++;
        for (int i = 1; i < frames.size(); i++) begin
            check_cnt++;
            if (frames[i].gap != FRAME_GAP) $display("FAIL b2b_gap idx=%0d got=%0d exp=%0d", i, frames[i].gap, FRAME_GAP);
            else pass_cnt++;
            check_cnt++;
            if (frames[i].val <= frames[i-1].val) $display("FAIL b2b_order idx=%0d got=%h exp>%h", i, frames[i].val, frames[i-1].val);
            else pass_cnt++;
        end
        if (frames.size() >= 1) begin
            check_cnt++;
            if (frames[frames.size()-1].val !== 16'h0100) $display("FAIL b2b_last_frame got=%h exp=0100", frames[frames.size()-1].val);
            else pass_cnt++;
        end
        model_cur = 16'h0100;
    endtask

    task automatic test_random();
        int nv;
        for (int k = 0; k < 6; k++) begin
            nv = model_cur + int'($urandom_range(0, 400)) - 200;
            if (nv < 0) nv = 0;
            if (nv > 65535) nv = 65535;
            if (k == 2) nv = model_cur;
            test_ramp(16'(nv));
        end
    endtask

    task automatic test_top();
        test_ramp(16'hFFF8);
        test_ramp(16'hFFFF);
    endtask

    task automatic test_reset_mid();
        int ok;
        comVolt = 16'hFF00;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (dac_if.dacCSn === 1'b0 && mon_bits == 7) begin ok = 1; break; end
        end
        check_cnt++; if (ok != 1) $display("FAIL rstmid_reach_bit7 got=%0d exp=1", ok); else pass_cnt++;
        n_rst   = 1'b0;
        comVolt = 16'h0000;
        #1;
        check_cnt++; if (dac_if.dacCSn !== 1'b1) $display("FAIL rstmid_csn got=%b exp=1", dac_if.dacCSn); else pass_cnt++;
        check_cnt++; if (dac_if.dacSCLK !== 1'b0) $display("FAIL rstmid_sclk got=%b exp=0", dac_if.dacSCLK); else pass_cnt++;
        check_cnt++; if (curVolt !== 16'h0000) $display("FAIL rstmid_cur got=%h exp=0000", curVolt); else pass_cnt++;
        check_cnt++; if (dacBusy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", dacBusy); else pass_cnt++;
        repeat (3) @(negedge clk);
        frames.delete();
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (rampDone === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check_cnt++; if (ok != 1) $display("FAIL rstmid_done_timeout got=%0d exp=1", ok); else pass_cnt++;
        check_cnt++; if (frames.size() != 1) $display("FAIL rstmid_frame_count got=%0d exp=1", frames.size()); else pass_cnt++;
        if (frames.size() >= 1) begin
            check_cnt++; if (frames[0].val !== 16'h0000) $display("FAIL rstmid_frame_val got=%h exp=0000", frames[0].val); else pass_cnt++;
            check_cnt++; if (frames[0].low != FRAME_LOW) $display("FAIL rstmid_csn_low got=%0d exp=%0d", frames[0].low, FRAME_LOW); else pass_cnt++;
        end
        model_cur = 0;
    endtask

    initial begin
        n_rst   = 1'b0;
        comVolt = 16'h0000;
        test_reset();
        test_ramp(16'h0040);
        test_clamp();
        test_glitch();
        test_back_to_back();
        test_random();
        test_top();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
